udp_tx_sched: RTL and testbench
===============================

UDP_TX_SCHED -- requirements
Module: udp_tx_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, 16'd50000, max cycles a MAC transaction may last (START+WAIT_FDN) before abort.
REQ-002 SHALL have parameter GAP, 8'd12, idle cycles enforced between consecutive MAC transactions.
REQ-003 clk  in  1  single clock, gmii_txc domain; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0 / req1  in  1 each  transmit request from requester 0 (ADC data) / requester 1 (command reply); held high until done.
REQ-006 len0 / len1  in  12 each  UDP payload length in bytes; stable while the matching req is high.
REQ-007 txd0 / txd1  in  8 each  payload byte from the requester's FIFO.
REQ-008 rden0 / rden1  out  1 each  FIFO read enable to the requester.
REQ-009 gnt0 / gnt1  out  1 each  grant, high for the whole owned transaction.
REQ-010 done0 / done1  out  1 each  one-cycle completion pulse.
REQ-011 fs_udp_tx  out  1  start flag to MAC UDP TX engine.
REQ-012 fd_udp_tx  in  1  done flag from MAC UDP TX engine.
REQ-013 udp_tx_len  out  12  length presented to MAC.
REQ-014 udp_txen  in  1  MAC byte request.
REQ-015 udp_txd  out  8  byte to MAC.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 err_timeout  out  1  sticky timeout flag.
REQ-018 frame_cnt  out  16  count of successfully completed frames.

Function
REQ-019 SHALL implement the states IDLE, ARB, START, WAIT_FDN, DONE and GAP.
REQ-020 IDLE SHALL move to ARB on the cycle after any req is seen high.
REQ-021 ARB SHALL select round-robin: the requester not served last wins when both req are high; after reset, requester 0 wins first.
REQ-022 ARB SHALL latch sel and len, and SHALL assert gnt_sel.
REQ-023 ARB: if the latched len = 0, the block SHALL go directly to DONE without any MAC transaction, and frame_cnt SHALL not increment.
REQ-024 ARB: otherwise the block SHALL go to START.
REQ-025 START SHALL hold fs_udp_tx=1 and udp_tx_len equal to the latched len.
REQ-026 START SHALL go to WAIT_FDN on the first cycle fd_udp_tx=1.
REQ-027 WAIT_FDN SHALL hold fs_udp_tx=0 and SHALL go to DONE on the first cycle fd_udp_tx=0 (four-phase handshake).
REQ-028 DONE SHALL last exactly one cycle.
REQ-029 DONE SHALL pulse done_sel=1, deassert gnt_sel, and increment frame_cnt (16-bit, wraps FFFF->0000) only if the transaction was not aborted.
REQ-030 DONE SHALL then go to GAP.
REQ-031 GAP SHALL count GAP cycles, then go to IDLE; GAP=0 SHALL mean GAP lasts one cycle.
REQ-032 Timeout counter SHALL clear on entry to START and increment each cycle in START and WAIT_FDN.
REQ-033 On reaching TIMEOUT, the block SHALL drop fs_udp_tx, set err_timeout (sticky until rst), and go to DONE; done_sel SHALL still pulse.
REQ-034 Datapath: udp_txd SHALL equal txd_sel and rden_sel SHALL equal udp_txen, both combinational, while gnt_sel=1.
REQ-035 The unselected rden SHALL be 0, and udp_txd SHALL be 8'h00 when no grant is active.
REQ-036 A req deasserted mid-transaction SHALL be ignored; the transaction SHALL complete normally.
REQ-037 A req still high after its done pulse SHALL be treated as a new request.
REQ-038 fd_udp_tx=1 while in IDLE, ARB or GAP SHALL be ignored.
REQ-039 At most one gnt SHALL be high in any cycle.

Reset
REQ-040 rst=1 SHALL force IDLE on the next edge, regardless of the current state.
REQ-041 Reset SHALL set the following to 0: fs_udp_tx, gnt*, done*, rden*, busy, err_timeout, frame_cnt, udp_tx_len, and the round-robin pointer (requester 0 preferred).
REQ-042 Reset mid-transaction SHALL drop fs_udp_tx and the grant on the next edge, with no done pulse.

Verification
REQ-043 req0=1, len0=12'd64; MAC model raises fd 10 cycles after fs and drops it 2 cycles after fs falls -> gnt0 high, fs high 10 cycles, udp_tx_len=64, done0 pulse 1 cycle, frame_cnt=1, busy low after GAP+1.
REQ-044 req0=req1=1 held through 3 frames -> grant order 0,1,0; never both gnt high; GAP idle cycles between fs pulses.
REQ-045 req1=1, len1=12'd0 -> done1 pulse with fs never asserted; frame_cnt unchanged.
REQ-046 TIMEOUT=16'd20, fd never rises -> fs drops after 20 cycles, err_timeout=1 sticky, done pulse, frame_cnt unchanged; a following normal frame completes.
REQ-047 rst asserted in START -> next cycle fs=0, gnt=0, busy=0, no done; after release, req1 and req0 both high -> req0 granted first.
REQ-048 udp_txen toggled during gnt1 with txd1=8'hA5 -> udp_txd=A5, rden1 follows udp_txen, rden0=0.

Source files
------------

// File: rtl/udp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_sched
// Purpose  : Round-robin scheduler that shares one MAC UDP TX engine between
//            two requesters, with a four-phase fs/fd handshake, a timeout
//            abort and an enforced inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_sched #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [7:0]  GAP     = 8'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [11:0] len0,
    input  logic [11:0] len1,
    input  logic [7:0]  txd0,
    input  logic [7:0]  txd1,
    output logic        rden0,
    output logic        rden1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        fs_udp_tx,
    input  logic        fd_udp_tx,
    output logic [11:0] udp_tx_len,
    input  logic        udp_txen,
    output logic [7:0]  udp_txd,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARB      = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_FDN = 3'd3,
        ST_DONE     = 3'd4,
        ST_GAP      = 3'd5
    } state_t;

    state_t      r_state;
    logic        r_sel;
    logic        r_ptr;
    logic [11:0] r_len;
    logic [15:0] r_tcnt;
    logic [7:0]  r_gcnt;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic        r_fs;
    logic        r_busy;
    logic        r_err;
    logic [15:0] r_frames;

    logic        w_pick;
    logic [11:0] w_pick_len;
    logic        w_tmo;
    logic        w_gap_end;

    // r_ptr names the requester preferred when both ask at once
    assign w_pick     = (req0 && req1) ? r_ptr : req1;
    assign w_pick_len = w_pick ? len1 : len0;
    assign w_tmo      = ({1'b0, r_tcnt} + 17'd1) >= {1'b0, TIMEOUT};
    assign w_gap_end  = ({1'b0, r_gcnt} + 9'd1) >= {1'b0, GAP};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_sel    <= 1'b0;
            r_ptr    <= 1'b0;
            r_len    <= 12'd0;
            r_tcnt   <= 16'd0;
            r_gcnt   <= 8'd0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_fs     <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
            r_frames <= 16'd0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        r_state <= ST_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    if (!(req0 || req1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_sel  <= w_pick;
                        r_ptr  <= ~w_pick;
                        r_len  <= w_pick_len;
                        r_gnt0 <= ~w_pick;
                        r_gnt1 <= w_pick;
                        if (w_pick_len == 12'd0) begin
                            r_state <= ST_DONE;
                            r_done0 <= ~w_pick;
                            r_done1 <= w_pick;
                        end else begin
                            r_state <= ST_START;
                            r_fs    <= 1'b1;
                            r_tcnt  <= 16'd0;
                        end
                    end
                end
                ST_START: begin
                    r_tcnt <= r_tcnt + 16'd1;
                    if (w_tmo) begin
                        r_fs    <= 1'b0;
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done0 <= ~r_sel;
                        r_done1 <= r_sel;
                    end else if (fd_udp_tx) begin
                        r_fs    <= 1'b0;
                        r_state <= ST_WAIT_FDN;
                    end
                end
                ST_WAIT_FDN: begin
                    r_tcnt <= r_tcnt + 16'd1;
                    if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                        r_done0 <= ~r_sel;
                        r_done1 <= r_sel;
                    end else if (!fd_udp_tx) begin
                        r_frames <= r_frames + 16'd1;
                        r_state  <= ST_DONE;
                        r_done0  <= ~r_sel;
                        r_done1  <= r_sel;
                    end
                end
                ST_DONE: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_gcnt  <= 8'd0;
                    r_state <= ST_GAP;
                end
                ST_GAP: begin
                    r_gcnt <= r_gcnt + 8'd1;
                    if (w_gap_end) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Byte path is combinational so the MAC sees FIFO data in its request cycle
    assign rden0   = r_gnt0 & udp_txen;
    assign rden1   = r_gnt1 & udp_txen;
    assign udp_txd = r_gnt0 ? txd0 : (r_gnt1 ? txd1 : 8'h00);

    assign gnt0        = r_gnt0;
    assign gnt1        = r_gnt1;
    assign done0       = r_done0;
    assign done1       = r_done1;
    assign fs_udp_tx   = r_fs;
    assign udp_tx_len  = r_len;
    assign busy        = r_busy;
    assign err_timeout = r_err;
    assign frame_cnt   = r_frames;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_sched
// Purpose  : Randomized self-checking bench for udp_tx_sched against a
//            transaction-level model of arbitration, handshake and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_sched;

    localparam logic [15:0] C_TMO = 16'd20;
    localparam logic [7:0]  C_GAP = 8'd3;
    localparam int          C_EXP_GAP = (C_GAP == 8'd0) ? 1 : int'(C_GAP);

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [11:0] len0, len1;
    logic [7:0]  txd0, txd1;
    logic        rden0, rden1, gnt0, gnt1, done0, done1;
    logic        fs_udp_tx, fd_udp_tx, udp_txen, busy, err_timeout;
    logic [11:0] udp_tx_len;
    logic [7:0]  udp_txd;
    logic [15:0] frame_cnt;

    udp_tx_sched #(.TIMEOUT(C_TMO), .GAP(C_GAP)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .len0(len0), .len1(len1),
        .txd0(txd0), .txd1(txd1), .rden0(rden0), .rden1(rden1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .fs_udp_tx(fs_udp_tx), .fd_udp_tx(fd_udp_tx), .udp_tx_len(udp_tx_len),
        .udp_txen(udp_txen), .udp_txd(udp_txd), .busy(busy),
        .err_timeout(err_timeout), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Reference model state
    bit          m_ptr    = 1'b0;
    logic [15:0] m_frames = 16'd0;
    bit          m_err    = 1'b0;

    // MAC engine model: fd rises after mac_delay fs-high cycles, falls 2 cycles after fs drops
    int mac_delay = 10;
    bit mac_en    = 1'b1;
    int mac_cnt   = 0;
    initial begin
        fd_udp_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (!mac_en) begin
                fd_udp_tx = 1'b0;
                mac_cnt   = 0;
            end else if (!fd_udp_tx) begin
                if (fs_udp_tx === 1'b1) begin
                    mac_cnt++;
                    if (mac_cnt >= mac_delay) begin
                        fd_udp_tx = 1'b1;
                        mac_cnt   = 0;
                    end
                end else begin
                    mac_cnt = 0;
                end
            end else if (fs_udp_tx === 1'b0) begin
                mac_cnt++;
                if (mac_cnt >= 2) begin
                    fd_udp_tx = 1'b0;
                    mac_cnt   = 0;
                end
            end
        end
    end

    // Byte path and grant exclusivity, checked every cycle once out of reset
    bit dp_on   = 1'b0;
    bit a5_mode = 1'b0;
    initial begin
        logic [7:0] exp_txd;
        udp_txen = 1'b0;
        txd0     = 8'h00;
        txd1     = 8'h00;
        forever begin
            @(negedge clk);
            if (dp_on) begin
                exp_txd = gnt0 ? txd0 : (gnt1 ? txd1 : 8'h00);
                check_val("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
                check_val("udp_txd", {24'd0, udp_txd}, {24'd0, exp_txd});
                check_val("rden0", {31'd0, rden0}, {31'd0, gnt0 & udp_txen});
                check_val("rden1", {31'd0, rden1}, {31'd0, gnt1 & udp_txen});
            end
            udp_txen = 1'($urandom_range(0, 1));
            txd0     = 8'($urandom);
            txd1     = a5_mode ? 8'hA5 : 8'($urandom);
        end
    end

    // One arbitration round from IDLE back to IDLE, checked against the model
    task automatic run_txn(input bit tmo, input bit drop);
        bit          exp_w;
        logic [11:0] exp_len;
        int          exp_fs;
        int          n;
        int          fs_cycles;
        exp_w   = (req0 && req1) ? m_ptr : req1;
        exp_len = exp_w ? len1 : len0;
        m_ptr   = ~exp_w;
        n = 0;
        while (!(gnt0 || gnt1) && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            check_val("grant_wait_expired", 32'd1, 32'd0);
            return;
        end
        check_val("grant", {30'd0, gnt1, gnt0}, exp_w ? 32'd2 : 32'd1);
        fs_cycles = 0;
        n = 0;
        while (!(done0 || done1) && n < 100) begin
            if (fs_udp_tx) begin
                fs_cycles++;
                if (fs_cycles == 1)
                    check_val("tx_len", {20'd0, udp_tx_len}, {20'd0, exp_len});
            end
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check_val("done_wait_expired", 32'd1, 32'd0);
            return;
        end
        check_val("done", {30'd0, done1, done0}, exp_w ? 32'd2 : 32'd1);
        exp_fs = (exp_len == 12'd0) ? 0 : (tmo ? int'(C_TMO) : mac_delay);
        check_val("fs_cycles", fs_cycles, exp_fs);
        if (exp_len != 12'd0) begin
            if (tmo) m_err = 1'b1;
            else     m_frames = m_frames + 16'd1;
        end
        check_val("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_frames});
        check_val("err_timeout", {31'd0, err_timeout}, {31'd0, m_err});
        if (drop) begin
            if (exp_w) req1 = 1'b0;
            else       req0 = 1'b0;
        end
        @(negedge clk);
        check_val("gnt_after_done", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("done_width", {30'd0, done1, done0}, 32'd0);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_val("gap_cycles", n, C_EXP_GAP);
    endtask

    initial begin
        int n;
        rst  = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        len0 = 12'd0;
        len1 = 12'd0;
        repeat (3) @(negedge clk);
        check_val("rst_fs", {31'd0, fs_udp_tx}, 32'd0);
        check_val("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("rst_done", {30'd0, done1, done0}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_err", {31'd0, err_timeout}, 32'd0);
        check_val("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_val("rst_tx_len", {20'd0, udp_tx_len}, 32'd0);
        check_val("rst_rden", {30'd0, rden1, rden0}, 32'd0);
        check_val("rst_txd", {24'd0, udp_txd}, 32'd0);
        rst   = 1'b0;
        dp_on = 1'b1;

        // Single 64-byte frame from requester 0
        req0 = 1'b1; len0 = 12'd64; mac_delay = 10;
        run_txn(1'b0, 1'b1);

        // Zero-length request completes without a MAC transaction
        req1 = 1'b1; len1 = 12'd0;
        run_txn(1'b0, 1'b1);

        // Requester 1 with a fixed payload byte
        a5_mode = 1'b1;
        req1 = 1'b1; len1 = 12'd5; mac_delay = 6;
        run_txn(1'b0, 1'b1);
        a5_mode = 1'b0;

        // Timeout abort followed by a normal frame
        mac_en = 1'b0;
        req0 = 1'b1; len0 = 12'd100;
        run_txn(1'b1, 1'b1);
        mac_en = 1'b1;
        req1 = 1'b1; len1 = 12'd7; mac_delay = 4;
        run_txn(1'b0, 1'b1);

        // Reset while in START, leaving the preference pointing at requester 1
        req0 = 1'b1; len0 = 12'd30; mac_delay = 15;
        n = 0;
        while (!fs_udp_tx && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("fs_before_reset", {31'd0, fs_udp_tx}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("midrst_fs", {31'd0, fs_udp_tx}, 32'd0);
        check_val("midrst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {30'd0, done1, done0}, 32'd0);
        check_val("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        check_val("midrst_err", {31'd0, err_timeout}, 32'd0);
        m_ptr = 1'b0; m_frames = 16'd0; m_err = 1'b0;
        rst = 1'b0;

        // Both held through three frames
        req0 = 1'b1; len0 = 12'd20;
        req1 = 1'b1; len1 = 12'd33;
        mac_delay = 3;
        run_txn(1'b0, 1'b0);
        run_txn(1'b0, 1'b0);
        run_txn(1'b0, 1'b0);
        req0 = 1'b0;
        req1 = 1'b0;

        // Randomized rounds
        for (int i = 0; i < 40; i++) begin
            bit tmo;
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1'b1;
                len0 = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1'b1;
                len1 = ($urandom_range(0, 7) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            end
            if (!req0 && !req1) begin
                req0 = 1'b1;
                len0 = 12'($urandom_range(1, 4095));
            end
            tmo       = ($urandom_range(0, 7) == 0);
            mac_en    = ~tmo;
            mac_delay = $urandom_range(1, 15);
            run_txn(tmo, 1'b1);
        end
        mac_en = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
